// File: rtl/frame_buffer_controller_if.sv
// Bundle of display-side, renderer-side and back-buffer write port signals
// for the double-buffer scheduler.
interface frame_buffer_controller_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 4
);
    logic                  ce;
    logic                  swap;
    logic                  render_start;
    logic                  render_ready;
    logic                  render_we;
    logic [ADDR_WIDTH-1:0] render_addr;
    logic [DATA_WIDTH-1:0] render_data;
    logic                  render_done;
    logic                  front_sel;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  frame_dropped;

    // Controller side
    modport master (
        input  ce, swap, render_we, render_addr, render_data, render_done,
        output render_start, render_ready, front_sel,
               mem_we, mem_addr, mem_data, frame_dropped
    );

    // Environment side (renderer, pixel iterator, memory)
    modport slave (
        output ce, swap, render_we, render_addr, render_data, render_done,
        input  render_start, render_ready, front_sel,
               mem_we, mem_addr, mem_data, frame_dropped
    );
endinterface

// File: rtl/frame_buffer_controller.sv
// Double-buffer scheduler: clears the back buffer, lets the renderer fill it,
// then flips front/back on the end-of-frame swap strobe.
module frame_buffer_controller #(
    parameter int unsigned ADDR_WIDTH  = 17,
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned CLEAR_WORDS = 76800,
    parameter int unsigned CLEAR_COLOR = 0
) (
    input  logic                       clk_rgb,
    input  logic                       rst_n,
    frame_buffer_controller_if.master  fb
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CLEAR_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] CLEAR_VAL = DATA_WIDTH'(CLEAR_COLOR);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RENDER,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  front_sel_q, front_sel_d;
    logic                  render_start_q, render_start_d;
    logic                  frame_dropped_q, frame_dropped_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  swap_ev;

    assign swap_ev = fb.swap & fb.ce;

    // State and registered outputs
    always_ff @(posedge clk_rgb) begin
        if (!rst_n) begin
            state_q         <= ST_CLEAR;
            clr_addr_q      <= '0;
            front_sel_q     <= 1'b0;
            render_start_q  <= 1'b0;
            frame_dropped_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            clr_addr_q      <= clr_addr_d;
            front_sel_q     <= front_sel_d;
            render_start_q  <= render_start_d;
            frame_dropped_q <= frame_dropped_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
        end
    end

    // Next state; mem_addr/mem_data hold unless a write is issued
    always_comb begin
        state_d         = state_q;
        clr_addr_d      = clr_addr_q;
        front_sel_d     = front_sel_q;
        render_start_d  = 1'b0;
        frame_dropped_d = 1'b0;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;

        case (state_q)
            ST_CLEAR: begin
                mem_we_d        = 1'b1;
                mem_addr_d      = clr_addr_q;
                mem_data_d      = CLEAR_VAL;
                frame_dropped_d = swap_ev;
                if (clr_addr_q == LAST_ADDR) begin
                    clr_addr_d     = '0;
                    render_start_d = 1'b1;
                    state_d        = ST_RENDER;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_RENDER: begin
                frame_dropped_d = swap_ev;
                if (fb.render_we) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = fb.render_addr;
                    mem_data_d = fb.render_data;
                end
                if (fb.render_done) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (swap_ev) begin
                    front_sel_d = ~front_sel_q;
                    state_d     = ST_CLEAR;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    assign fb.render_start  = render_start_q;
    assign fb.render_ready  = (state_q == ST_RENDER);
    assign fb.front_sel     = front_sel_q;
    assign fb.frame_dropped = frame_dropped_q;
    assign fb.mem_we        = mem_we_q;
    assign fb.mem_addr      = mem_addr_q;
    assign fb.mem_data      = mem_data_q;
endmodule

// File: tb/tb_frame_buffer_controller.sv
// Directed bench for frame_buffer_controller with a write scoreboard on the
// back-buffer port; runs with an 8-word clear.
module tb_frame_buffer_controller;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk_rgb;
    logic rst_n;
    wr_t  exp_q[$];
    int   total;
    int   passed;

    frame_buffer_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fb ();

    frame_buffer_controller #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_WORDS(CW),
        .CLEAR_COLOR(0)
    ) dut (
        .clk_rgb(clk_rgb),
        .rst_n  (rst_n),
        .fb     (fb)
    );

    initial clk_rgb = 1'b0;
    always #5 clk_rgb = ~clk_rgb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle, then compare any write on the mem port with the scoreboard
    task automatic tick();
        wr_t e;
        @(posedge clk_rgb);
        #1;
        if (fb.mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_mem_we", 32'(fb.mem_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", 32'(fb.mem_addr), 32'(e.addr));
                chk("mem_data", 32'(fb.mem_data), 32'(e.data));
            end
        end
    endtask

    // Full clear sequence; optional swap_ev / render_done injected at given steps
    task automatic clear_frame(input int drop_at, input int done_at, input logic exp_fs);
        for (int i = 0; i < int'(CW); i++) exp_q.push_back('{addr: AW'(i), data: '0});
        for (int i = 0; i < int'(CW); i++) begin
            fb.swap        = (i == drop_at);
            fb.ce          = (i == drop_at);
            fb.render_done = (i == done_at);
            tick();
            fb.swap        = 1'b0;
            fb.ce          = 1'b0;
            fb.render_done = 1'b0;
            chk("clr_render_start", 32'(fb.render_start), 32'(i == int'(CW) - 1));
            chk("clr_front_sel", 32'(fb.front_sel), 32'(exp_fs));
            chk("clr_frame_dropped", 32'(fb.frame_dropped), 32'(i == drop_at));
        end
        chk("clr_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("clr_render_ready", 32'(fb.render_ready), 32'd1);
    endtask

    initial begin
        total          = 0;
        passed         = 0;
        rst_n          = 1'b0;
        fb.ce          = 1'b0;
        fb.swap        = 1'b0;
        fb.render_we   = 1'b0;
        fb.render_addr = '0;
        fb.render_data = '0;
        fb.render_done = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_front_sel", 32'(fb.front_sel), 32'd0);
        chk("rst_mem_we", 32'(fb.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(fb.mem_addr), 32'd0);
        chk("rst_mem_data", 32'(fb.mem_data), 32'd0);
        chk("rst_render_start", 32'(fb.render_start), 32'd0);
        chk("rst_frame_dropped", 32'(fb.frame_dropped), 32'd0);
        chk("rst_render_ready", 32'(fb.render_ready), 32'd0);

        // Initial clear after reset release
        rst_n = 1'b1;
        clear_frame(-1, -1, 1'b0);
        tick();
        chk("idle_mem_we", 32'(fb.mem_we), 32'd0);
        chk("idle_render_start", 32'(fb.render_start), 32'd0);
        chk("idle_mem_addr_hold", 32'(fb.mem_addr), 32'd7);

        // Render pass-through, second write alongside render_done
        fb.render_we   = 1'b1;
        fb.render_addr = AW'(3);
        fb.render_data = DW'(4'hA);
        exp_q.push_back('{addr: AW'(3), data: DW'(4'hA)});
        tick();
        chk("rnd_ready_mid", 32'(fb.render_ready), 32'd1);
        fb.render_addr = AW'(5);
        fb.render_data = DW'(4'h2);
        fb.render_done = 1'b1;
        exp_q.push_back('{addr: AW'(5), data: DW'(4'h2)});
        tick();
        fb.render_we   = 1'b0;
        fb.render_done = 1'b0;
        chk("rnd_ready_after_done", 32'(fb.render_ready), 32'd0);
        chk("rnd_queue_drained", 32'(exp_q.size()), 32'd0);

        // ce gating in WAIT; renderer writes must be ignored here too
        fb.swap        = 1'b1;
        fb.ce          = 1'b0;
        fb.render_we   = 1'b1;
        fb.render_addr = AW'(9);
        fb.render_data = DW'(4'h5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_front_sel", 32'(fb.front_sel), 32'd0);
            chk("gate_frame_dropped", 32'(fb.frame_dropped), 32'd0);
            chk("gate_mem_we", 32'(fb.mem_we), 32'd0);
        end
        fb.render_we = 1'b0;

        // Normal flip, with a dropped-frame swap in the middle of the following clear
        fb.ce = 1'b1;
        tick();
        fb.swap = 1'b0;
        fb.ce   = 1'b0;
        chk("flip_front_sel", 32'(fb.front_sel), 32'd1);
        chk("flip_frame_dropped", 32'(fb.frame_dropped), 32'd0);
        chk("flip_mem_we", 32'(fb.mem_we), 32'd0);
        clear_frame(3, -1, 1'b1);
        tick();

        // swap_ev coincident with render_done: dropped, no flip
        fb.render_we   = 1'b1;
        fb.render_addr = AW'(1);
        fb.render_data = DW'(4'h7);
        fb.render_done = 1'b1;
        fb.swap        = 1'b1;
        fb.ce          = 1'b1;
        exp_q.push_back('{addr: AW'(1), data: DW'(4'h7)});
        tick();
        fb.render_we   = 1'b0;
        fb.render_done = 1'b0;
        fb.swap        = 1'b0;
        fb.ce          = 1'b0;
        chk("drop2_frame_dropped", 32'(fb.frame_dropped), 32'd1);
        chk("drop2_front_sel", 32'(fb.front_sel), 32'd1);
        chk("drop2_render_ready", 32'(fb.render_ready), 32'd0);
        tick();
        chk("drop2_pulse_end", 32'(fb.frame_dropped), 32'd0);

        // Next swap_ev in WAIT flips; render_done during clear is ignored
        fb.swap = 1'b1;
        fb.ce   = 1'b1;
        tick();
        fb.swap = 1'b0;
        fb.ce   = 1'b0;
        chk("flip2_front_sel", 32'(fb.front_sel), 32'd0);
        chk("flip2_frame_dropped", 32'(fb.frame_dropped), 32'd0);
        clear_frame(-1, 2, 1'b0);

        // One more frame to get front_sel=1 while rendering
        fb.render_done = 1'b1;
        tick();
        fb.render_done = 1'b0;
        fb.swap        = 1'b1;
        fb.ce          = 1'b1;
        tick();
        fb.swap = 1'b0;
        fb.ce   = 1'b0;
        chk("flip3_front_sel", 32'(fb.front_sel), 32'd1);
        clear_frame(-1, -1, 1'b1);

        // Reset mid-render aborts the frame and restarts the clear at 0
        rst_n          = 1'b0;
        fb.render_we   = 1'b1;
        fb.render_addr = AW'(4);
        fb.render_data = DW'(4'h3);
        tick();
        fb.render_we = 1'b0;
        chk("mrst_front_sel", 32'(fb.front_sel), 32'd0);
        chk("mrst_render_ready", 32'(fb.render_ready), 32'd0);
        chk("mrst_mem_we", 32'(fb.mem_we), 32'd0);
        rst_n = 1'b1;
        clear_frame(-1, -1, 1'b0);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/frame_buffer_controller.md
# frame_buffer_controller

Double-buffer scheduler between the game renderer and the display scan-out. It owns the buffer-select bit read by the display side and the single write port of the back buffer. It sequences clear, render and wait-for-swap phases, flipping buffers only on the pixel iterator's end-of-frame `swap` pulse. If the renderer has not finished when `swap` arrives, it reports a dropped frame.

## Interface
- `ADDR_WIDTH`, 17: back-buffer word address width.
- `DATA_WIDTH`, 4: pixel word width.
- `CLEAR_WORDS`, 76800: words cleared per frame, addresses 0..`CLEAR_WORDS`-1; must be ≤ 2^`ADDR_WIDTH`.
- `CLEAR_COLOR`, 0: value written during clear.

Ports:
- `clk_rgb` in 1: pixel-domain clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ce` in 1: pixel clock enable; qualifies `swap` only.
- `swap` in 1: end-of-frame strobe from the pixel iterator; valid when `ce`=1.
- `render_start` out 1: one-cycle pulse, renderer may begin the frame.
- `render_ready` out 1: high while renderer writes are accepted.
- `render_we` in 1: renderer write strobe.
- `render_addr` in `ADDR_WIDTH`: renderer write address.
- `render_data` in `DATA_WIDTH`: renderer write data.
- `render_done` in 1: one-cycle pulse, frame complete.
- `front_sel` out 1: buffer index the display reads; the back buffer is `~front_sel`.
- `mem_we` out 1: back-buffer write enable.
- `mem_addr` out `ADDR_WIDTH`: back-buffer write address.
- `mem_data` out `DATA_WIDTH`: back-buffer write data.
- `frame_dropped` out 1: one-cycle pulse, `swap` arrived before the frame was ready.

## Operation
- `swap_ev` = `swap` & `ce`. `render_done` and `render_we` are sampled every cycle and are not gated by `ce`.
- State machine has three states: CLEAR, RENDER, WAIT.
- CLEAR:
  - Each cycle writes `CLEAR_COLOR` to `clr_addr`, then increments `clr_addr`.
  - When `clr_addr` = `CLEAR_WORDS`-1 is written: go to RENDER, reset `clr_addr` to 0, and pulse `render_start` on the next cycle.
- RENDER:
  - `render_ready`=1.
  - A cycle with `render_we`=1 forwards addr/data to the mem port.
  - `render_done` moves the state to WAIT. A write in the same cycle as `render_done` is still accepted.
- WAIT:
  - `render_ready`=0 and `render_we` is ignored.
  - On `swap_ev`: toggle `front_sel` and go to CLEAR.
- `swap_ev` in CLEAR or RENDER: pulse `frame_dropped`, no flip, no state change. This includes `swap_ev` coinciding with `render_done`; that frame flips on the next `swap_ev`.
- `render_done` outside RENDER is ignored.
- `render_addr` ≥ `CLEAR_WORDS` is passed through unchecked.

## Timing
- Reset values (`rst_n`=0 at a rising edge):
  - State = CLEAR, `clr_addr`=0, `front_sel`=0.
  - `render_start`=0, `frame_dropped`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0.
- Reset mid-operation aborts any clear or render. The first clear write appears on `mem_*` 1 cycle after `rst_n` returns high.
- All outputs are registered except `render_ready`, which is decoded from the state (high exactly while state = RENDER).
- Mem port latency is 1 cycle: an input accepted, or a clear address issued, at edge N appears on `mem_we`/`mem_addr`/`mem_data` after edge N+1.
- Clear takes `CLEAR_WORDS` consecutive cycles with `mem_we`=1. The last clear write and `render_start` are high in the same output cycle.
- `front_sel` changes 1 cycle after `swap_ev`. The first clear write of the new back buffer appears 1 cycle after that, with `front_sel` already at its new value.
- `frame_dropped` is high 1 cycle after the offending `swap_ev`.
- Outside CLEAR writes and accepted render writes, `mem_we`=0. `mem_addr`/`mem_data` hold their last values.

## Test plan
- **Reset and clear, `CLEAR_WORDS`=8:**
  - Stimulus: release `rst_n`.
  - Required: `mem_we`=1 for exactly 8 cycles, addresses 0..7, data 0.
  - Required: `render_start` high with address 7; `front_sel`=0 throughout.
- **Render pass-through:**
  - Stimulus: in RENDER, write addr 3 / data 0xA, then addr 5 / data 0x2 together with `render_done`.
  - Required: both writes appear one cycle later, in order.
  - Required: `render_ready` drops on the cycle after `render_done`.
- **Normal flip:**
  - Stimulus: in WAIT, apply `swap`=1 with `ce`=1.
  - Required: `front_sel` becomes 1 the next cycle; an 8-word clear follows; `frame_dropped` stays 0.
- **`ce` gating:**
  - Stimulus: in WAIT, apply `swap`=1 with `ce`=0 for 5 cycles.
  - Required: no flip and no drop.
- **Dropped frame:**
  - Stimulus: apply `swap_ev` during CLEAR, and again in the same cycle as `render_done`.
  - Required: one `frame_dropped` pulse each time, `front_sel` unchanged.
  - Required: the next `swap_ev` in WAIT flips the buffers.
- **Reset mid-render:**
  - Stimulus: assert `rst_n`=0 for 1 cycle with `front_sel`=1 during RENDER.
  - Required: `front_sel`=0, `render_ready`=0, clear restarts at address 0.
